// File: rtl/pipelined_adder.sv
// WIDTH-bit adder split into STAGES carry-chained chunks, one chunk per register stage.
// Valid/ready on both sides with a single global stall; saturation applied at the last stage.
module pipelined_adder #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             signed_mode,
    input  logic             saturate,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             sat
);

    // Handshake: a transfer happens on a rising edge where valid && ready are both 1.
    // ready never depends on valid on the same side; in_ready is 1 whenever the
    // output register is empty or being drained this cycle.
    localparam int CW = WIDTH / STAGES;
    localparam int L  = STAGES - 1;

    // Stage k registers: full operands travel along so the last stage sees the MSBs.
    logic [STAGES-1:0] r_v, r_c, r_sm, r_se;
    logic [WIDTH-1:0]  r_a [STAGES];
    logic [WIDTH-1:0]  r_b [STAGES];
    logic [WIDTH-1:0]  r_s [STAGES];
    logic              r_cout, r_ovf, r_sat;

    logic [STAGES-1:0] i_v, i_c, i_sm, i_se, n_c;
    logic [WIDTH-1:0]  i_a [STAGES];
    logic [WIDTH-1:0]  i_b [STAGES];
    logic [WIDTH-1:0]  i_s [STAGES];
    logic [WIDTH-1:0]  n_s [STAGES];
    logic [CW:0]       chunk;
    logic [WIDTH-1:0]  raw, f_sum;
    logic              a_msb, b_msb, f_cout, f_ovf, f_sat;
    logic              sm_in, advance;

    assign advance   = !r_v[L] || out_ready;
    assign in_ready  = advance;
    assign out_valid = r_v[L];
    assign sum       = r_s[L];
    assign cout      = r_cout;
    assign overflow  = r_ovf;
    assign sat       = r_sat;

    // Only a definite 1 selects signed mode; X or Z fall to unsigned.
    always_comb begin
        sm_in = 1'b0;
        if (signed_mode) sm_in = 1'b1;
    end

    always_comb begin
        i_v[0]  = in_valid;
        i_c[0]  = cin;
        i_sm[0] = sm_in;
        i_se[0] = saturate;
        i_a[0]  = a;
        i_b[0]  = b;
        i_s[0]  = '0;
        for (int k = 1; k < STAGES; k++) begin
            i_v[k]  = r_v[k-1];
            i_c[k]  = r_c[k-1];
            i_sm[k] = r_sm[k-1];
            i_se[k] = r_se[k-1];
            i_a[k]  = r_a[k-1];
            i_b[k]  = r_b[k-1];
            i_s[k]  = r_s[k-1];
        end

        chunk = '0;
        for (int k = 0; k < STAGES; k++) begin
            chunk = {1'b0, i_a[k][k*CW +: CW]} + {1'b0, i_b[k][k*CW +: CW]}
                  + {{CW{1'b0}}, i_c[k]};
            n_c[k] = chunk[CW];
            n_s[k] = i_s[k];
            n_s[k][k*CW +: CW] = chunk[CW-1:0];
        end

        raw   = n_s[L];
        a_msb = i_a[L][WIDTH-1];
        b_msb = i_b[L][WIDTH-1];
        f_ovf = i_sm[L] && (a_msb == b_msb) && (raw[WIDTH-1] != a_msb);
        // Sign-extended carry equals the unsigned carry xor both sign bits.
        f_cout = i_sm[L] ? (a_msb ^ b_msb ^ n_c[L]) : n_c[L];
        f_sum  = raw;
        f_sat  = 1'b0;
        if (i_se[L] && !i_sm[L] && n_c[L]) begin
            f_sum = '1;
            f_sat = 1'b1;
        end else if (i_se[L] && f_ovf) begin
            f_sum = {a_msb, {(WIDTH-1){!a_msb}}};
            f_sat = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v    <= '0;
            r_c    <= '0;
            r_sm   <= '0;
            r_se   <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
            r_sat  <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                r_a[k] <= '0;
                r_b[k] <= '0;
                r_s[k] <= '0;
            end
        end else if (advance) begin
            for (int k = 0; k < STAGES; k++) begin
                r_v[k] <= i_v[k];
                if (i_v[k]) begin
                    r_a[k]  <= i_a[k];
                    r_b[k]  <= i_b[k];
                    r_s[k]  <= (k == L) ? f_sum : n_s[k];
                    r_c[k]  <= n_c[k];
                    r_sm[k] <= i_sm[k];
                    r_se[k] <= i_se[k];
                end
            end
            if (i_v[L]) begin
                r_cout <= f_cout;
                r_ovf  <= f_ovf;
                r_sat  <= f_sat;
            end
        end
    end

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder (WIDTH=64, STAGES=4): directed corner cases,
// backpressure, random streaming against an arithmetic reference model, and mid-flight reset.
module tb_pipelined_adder;

    localparam int W  = 64;
    localparam int S  = 4;
    localparam int RW = W + 3;

    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, cin, signed_mode, saturate;
    logic         out_valid, out_ready, cout, overflow, sat;
    logic [W-1:0] a, b, sum;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [RW-1:0] exp_q[$];

    typedef struct {
        logic [W-1:0] va, vb;
        logic         vc, vsm, vse;
        logic [W-1:0] es;
        logic         eco, eov, est;
    } vec_t;

    pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .signed_mode(signed_mode), .saturate(saturate),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout),
        .overflow(overflow), .sat(sat)
    );

    // Clock / reset
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference model from exact integer arithmetic: {sum, cout, overflow, sat}
    function automatic logic [RW-1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                            input logic mc, input logic msm, input logic mse);
        logic [W:0]          u;
        logic signed [W+1:0] ex, max_s, min_s;
        logic [W-1:0]        s;
        logic                co, ov, st;
        max_s = {3'b000, {(W-1){1'b1}}};
        min_s = {3'b111, {(W-1){1'b0}}};
        if (msm === 1'b1) begin
            ex = $signed({{2{ma[W-1]}}, ma}) + $signed({{2{mb[W-1]}}, mb})
               + $signed({{(W+1){1'b0}}, mc});
            co = ex[W];
            ov = (ex > max_s) || (ex < min_s);
            st = mse && ov;
            s  = ex[W-1:0];
            if (st) s = (ex > max_s) ? max_s[W-1:0] : min_s[W-1:0];
        end else begin
            u  = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mc};
            co = u[W];
            ov = 1'b0;
            st = mse && co;
            s  = st ? {W{1'b1}} : u[W-1:0];
        end
        return {s, co, ov, st};
    endfunction

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return {W{1'b1}};
            1:       return {1'b0, {(W-1){1'b1}}};
            2:       return {1'b1, {(W-1){1'b0}}};
            3:       return '0;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic test_reset;
        int bad_v = 0;
        int bad_r = 0;
        rst = 1'b1; in_valid = 1'b1; a = 64'd5; b = 64'd6; cin = 1'b0;
        signed_mode = 1'b0; saturate = 1'b0; out_ready = 1'b1;
        tick; tick;
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid);
        else pass_cnt++;
        total_cnt++;
        if ({sum, cout, overflow, sat} !== {RW{1'b0}})
            $display("FAIL reset_outputs: got %h want 0", {sum, cout, overflow, sat});
        else pass_cnt++;
        rst = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick;
            if (out_valid !== 1'b0) bad_v++;
            if (in_ready !== 1'b1) bad_r++;
        end
        total_cnt++;
        if (bad_v != 0) $display("FAIL reset_input_ignored: out_valid seen %0d cycles want 0", bad_v);
        else pass_cnt++;
        total_cnt++;
        if (bad_r != 0) $display("FAIL reset_in_ready: in_ready low %0d cycles want 0", bad_r);
        else pass_cnt++;
    endtask

    task automatic test_directed;
        vec_t vt[6];
        vt[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0};
        vt[1] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b1, 1'b0,
                  64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0};
        vt[2] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b1, 1'b1,
                  64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b1};
        vt[3] = '{64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b1,
                  64'h8000_0000_0000_0000, 1'b1, 1'b1, 1'b1};
        vt[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h2, 1'b0, 1'b0, 1'b1,
                  64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1};
        vt[5] = '{64'h1, 64'h1, 1'b0, 1'bx, 1'b1, 64'h2, 1'b0, 1'b0, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; a = vt[i].va; b = vt[i].vb; cin = vt[i].vc;
            signed_mode = vt[i].vsm; saturate = vt[i].vse;
            tick;
            in_valid = 1'b0; signed_mode = 1'b0;
            tick; tick;
            total_cnt++;
            if (out_valid !== 1'b0) $display("FAIL directed%0d_early: out_valid %b want 0", i, out_valid);
            else pass_cnt++;
            tick;
            total_cnt++;
            if (out_valid !== 1'b1) $display("FAIL directed%0d_latency: out_valid %b want 1", i, out_valid);
            else pass_cnt++;
            total_cnt++;
            if ({sum, cout, overflow, sat} !== {vt[i].es, vt[i].eco, vt[i].eov, vt[i].est})
                $display("FAIL directed%0d_result: got sum=%h c=%b o=%b s=%b want sum=%h c=%b o=%b s=%b",
                         i, sum, cout, overflow, sat, vt[i].es, vt[i].eco, vt[i].eov, vt[i].est);
            else pass_cnt++;
        end
        tick;
    endtask

    task automatic test_back_to_back;
        int sent = 0, got = 0, stall_left = 0, stall_cycles = 0, bad_ready = 0, cyc = 0, late = 0;
        bit first_seen = 0;
        logic [RW-1:0] exp;
        exp_q.delete();
        while (got < 8 && cyc < 60) begin
            if (out_valid && !first_seen) begin
                first_seen = 1; stall_left = 3; out_ready = 1'b1;
            end else if (stall_left > 0) begin
                out_ready = 1'b0; stall_left--;
            end else begin
                out_ready = 1'b1;
            end
            if (sent < 8) begin
                in_valid = 1'b1; a = 64'(sent + 1); b = 64'(sent + 1) << 16;
                cin = 1'b0; signed_mode = 1'b0; saturate = 1'b0;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (in_ready !== !(out_valid && !out_ready)) bad_ready++;
            if (out_valid && !out_ready) stall_cycles++;
            if (out_valid && out_ready) begin
                total_cnt++;
                if (exp_q.size() == 0) begin
                    $display("FAIL b2b_extra: got sum=%h with no result pending", sum);
                end else begin
                    exp = exp_q.pop_front();
                    if ({sum, cout, overflow, sat} !== exp)
                        $display("FAIL b2b_result%0d: got %h want %h", got, {sum, cout, overflow, sat}, exp);
                    else pass_cnt++;
                end
                got++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, cin, signed_mode, saturate));
                sent++;
            end
            tick;
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        total_cnt++;
        if (got != 8) $display("FAIL b2b_count: got %0d results want 8", got); else pass_cnt++;
        total_cnt++;
        if (stall_cycles != 3) $display("FAIL b2b_stall: stalled %0d cycles want 3", stall_cycles);
        else pass_cnt++;
        total_cnt++;
        if (bad_ready != 0) $display("FAIL b2b_in_ready: wrong in %0d cycles want 0", bad_ready);
        else pass_cnt++;
        for (int i = 0; i < 6; i++) begin
            tick;
            if (out_valid) late++;
        end
        total_cnt++;
        if (late != 0 || exp_q.size() != 0)
            $display("FAIL b2b_duplicates: extra valid %0d cycles, pending %0d want 0/0", late, exp_q.size());
        else pass_cnt++;
    endtask

    task automatic test_random;
        int bad_ready = 0, errs = 0, outs = 0, drain = 0;
        logic [RW-1:0] exp;
        exp_q.delete();
        for (int cyc = 0; cyc < 400; cyc++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            a = pick_operand(); b = pick_operand();
            cin = 1'($urandom_range(0, 1)); signed_mode = 1'($urandom_range(0, 1));
            saturate = 1'($urandom_range(0, 1));
            #1;
            if (in_ready !== !(out_valid && !out_ready)) bad_ready++;
            if (out_valid && out_ready) begin
                outs++;
                exp = (exp_q.size() != 0) ? exp_q.pop_front() : {RW{1'bx}};
                if ({sum, cout, overflow, sat} !== exp) begin
                    errs++;
                    if (errs <= 5) $display("FAIL random_result: got %h want %h", {sum, cout, overflow, sat}, exp);
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, signed_mode, saturate));
            tick;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        while (exp_q.size() != 0 && drain < 20) begin
            #1;
            if (out_valid) begin
                outs++;
                exp = exp_q.pop_front();
                if ({sum, cout, overflow, sat} !== exp) begin
                    errs++;
                    if (errs <= 5) $display("FAIL random_drain: got %h want %h", {sum, cout, overflow, sat}, exp);
                end
            end
            tick;
            drain++;
        end
        total_cnt++;
        if (errs != 0 || outs == 0) $display("FAIL random_stream: %0d wrong of %0d results want 0 wrong", errs, outs);
        else pass_cnt++;
        total_cnt++;
        if (exp_q.size() != 0) $display("FAIL random_drain_timeout: %0d pending want 0", exp_q.size());
        else pass_cnt++;
        total_cnt++;
        if (bad_ready != 0) $display("FAIL random_in_ready: wrong in %0d cycles want 0", bad_ready);
        else pass_cnt++;
    endtask

    task automatic test_reset_midflight;
        int bad_v = 0, bad_o = 0;
        logic [RW-1:0] exp;
        out_ready = 1'b1; signed_mode = 1'b0; saturate = 1'b0; cin = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; a = {$urandom, $urandom}; b = {$urandom, $urandom};
            tick;
        end
        in_valid = 1'b0; rst = 1'b1;
        tick;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid !== 1'b0) bad_v++;
            if ({sum, cout, overflow, sat} !== {RW{1'b0}}) bad_o++;
            tick;
        end
        total_cnt++;
        if (bad_v != 0) $display("FAIL midreset_valid: out_valid high %0d cycles want 0", bad_v);
        else pass_cnt++;
        total_cnt++;
        if (bad_o != 0) $display("FAIL midreset_outputs: nonzero %0d cycles want 0", bad_o);
        else pass_cnt++;
        in_valid = 1'b1; a = {$urandom, $urandom}; b = {$urandom, $urandom}; cin = 1'b1;
        exp = model(a, b, cin, 1'b0, 1'b0);
        tick;
        in_valid = 1'b0;
        tick; tick;
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL midreset_early: out_valid %b want 0", out_valid);
        else pass_cnt++;
        tick;
        total_cnt++;
        if (out_valid !== 1'b1 || {sum, cout, overflow, sat} !== exp)
            $display("FAIL midreset_next: valid=%b got %h want valid=1 %h", out_valid, {sum, cout, overflow, sat}, exp);
        else pass_cnt++;
        tick;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_midflight();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
